// File: rtl/axis_ic_pkg.sv
// axis_ic_pkg: shared types and helpers for the AXI4-Stream interconnect blocks.
package axis_ic_pkg;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int DEST_W_DEF  = 5;
    localparam int MAX_MASTERS = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++)
            if (oh[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin picker; searches upward from last+1 with wrap,
// ignoring requesters set in mask.
module axis_rr_pick
    import axis_ic_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    logic [N-1:0]  req_m;
    logic [IW-1:0] k;

    assign req_m = req & ~mask;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        k       = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last) + i) % N);
            if (!any_req && req_m[k]) begin
                any_req = 1'b1;
                gnt[k]  = 1'b1;
                idx     = k;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: N-to-1 AXI4-Stream round-robin arbiter, grant locked from first beat
// through tlast, zero-buffer combinational pass-through.
module axis_rr_arbiter
    import axis_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEST_W      = DEST_W_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                          i_sclk,
    input  logic                          i_srst_n,
    input  logic [NUM_MASTERS-1:0]        i_s_tvalid,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_s_tdata,
    input  logic [NUM_MASTERS*DEST_W-1:0] i_s_tdest,
    input  logic [NUM_MASTERS-1:0]        i_s_tlast,
    output logic [NUM_MASTERS-1:0]        o_s_tready,
    output logic                          o_m_tvalid,
    output logic [DATA_W-1:0]             o_m_tdata,
    output logic [DEST_W-1:0]             o_m_tdest,
    output logic                          o_m_tlast,
    input  logic                          i_m_tready,
    output logic [NUM_MASTERS-1:0]        o_grant,
    output logic                          o_busy,
    output logic [CNT_W-1:0]              o_pkt_cnt
);

    localparam int IW = $clog2(NUM_MASTERS);

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, pick_gnt, mask;
    logic [IW-1:0]          last_grant, pick_idx, g;
    logic [CNT_W-1:0]       pkt_cnt;
    logic                   pick_any, xfer, g_valid, g_last, done, load;

    assign g       = IW'(onehot_to_idx(MAX_MASTERS'(grant)));
    assign xfer    = state == XFER;
    assign g_valid = i_s_tvalid[g];
    assign g_last  = i_s_tlast[g];
    assign done    = xfer && g_valid && i_m_tready && g_last;
    // the finishing master is excluded from the same-cycle pick so others get a turn
    assign mask    = done ? grant : '0;
    assign load    = !xfer || done;

    axis_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req     (i_s_tvalid),
        .last    (last_grant),
        .mask    (mask),
        .gnt     (pick_gnt),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge i_sclk or negedge i_srst_n) begin
        if (!i_srst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = load ? (pick_any ? XFER : IDLE) : XFER;
    end

    always_ff @(posedge i_sclk or negedge i_srst_n) begin
        if (!i_srst_n) begin
            grant      <= '0;
            last_grant <= IW'(NUM_MASTERS - 1);
            pkt_cnt    <= '0;
        end else begin
            if (load) grant <= pick_gnt;
            if (load && pick_any) last_grant <= pick_idx;
            if (done) pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    always_comb begin
        o_s_tready = (xfer && i_m_tready) ? grant : '0;
        o_m_tvalid = xfer && g_valid;
        o_m_tlast  = xfer && g_last;
        o_m_tdata  = xfer ? i_s_tdata[g*DATA_W +: DATA_W] : '0;
        o_m_tdest  = xfer ? i_s_tdest[g*DEST_W +: DEST_W] : '0;
        o_grant    = grant;
        o_busy     = xfer;
        o_pkt_cnt  = pkt_cnt;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

N-to-1 AXI4-Stream arbiter for the stream interconnect. It shares one downstream stream port, the slave endpoint, between NUM_MASTERS upstream masters. Arbitration is round-robin, and a grant is locked for the whole packet, from the first beat through the tlast beat. Beats pass through combinationally once a grant is held; the arbiter adds no data buffering.

## Interface
Parameters:
- NUM_MASTERS, 4: number of upstream masters, 2..8
- DATA_W, 8: tdata width
- DEST_W, 5: tdest width
- CNT_W, 16: packet-counter width

Ports (flattened buses; master k occupies slice k):
- i_sclk  in  1  clock, rising edge
- i_srst_n  in  1  asynchronous, active-low reset
- i_s_tvalid  in  NUM_MASTERS  per-master tvalid
- i_s_tdata  in  NUM_MASTERS*DATA_W  per-master tdata
- i_s_tdest  in  NUM_MASTERS*DEST_W  per-master tdest
- i_s_tlast  in  NUM_MASTERS  per-master tlast
- o_s_tready  out  NUM_MASTERS  per-master tready
- o_m_tvalid  out  1  downstream tvalid
- o_m_tdata  out  DATA_W  downstream tdata
- o_m_tdest  out  DEST_W  downstream tdest
- o_m_tlast  out  1  downstream tlast
- i_m_tready  in  1  downstream tready
- o_grant  out  NUM_MASTERS  one-hot current grant; zero when idle
- o_busy  out  1  high in XFER
- o_pkt_cnt  out  CNT_W  packets forwarded since reset, wraps

## Operation
- States: IDLE and XFER. Registered state: grant (one-hot), last_grant index, pkt_cnt.
- Round-robin pick: search from (last_grant+1) mod NUM_MASTERS upward with wrap. The first master with tvalid=1 wins.
- IDLE:
  - If any i_s_tvalid is high, register the pick into grant and last_grant, then go to XFER.
  - Otherwise stay in IDLE.
  - All tready outputs are 0.
- XFER, with granted master g:
  - o_m_tvalid/tdata/tdest/tlast = master g's signals.
  - o_s_tready[g] = i_m_tready; all other tready bits are 0.
  - A beat transfers when i_s_tvalid[g] && i_m_tready.
- Packet end: on the handshake of a beat with tlast=1:
  - pkt_cnt increments.
  - Master g's request is masked for that cycle's pick.
  - If any other master is valid, grant the pick next cycle and stay in XFER, with no bubble.
  - Otherwise go to IDLE.
- While the grant is locked:
  - tvalid dropping mid-packet does not release the grant.
  - Requests from other masters are ignored until the tlast handshake.
- Outputs outside XFER: o_m_tvalid=0, o_m_tlast=0, o_m_tdata=0, o_m_tdest=0.
- A single requester re-requesting after its tlast is served again after one IDLE cycle.
- tdest is forwarded unmodified; routing by tdest is the slave side's job.

## Timing
- Reset values (async assert, sync release):
  - state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (master 0 has first priority), pkt_cnt=0.
  - All tready, o_m_tvalid and o_busy are 0.
- Reset mid-packet: the grant is dropped immediately and the packet is truncated. No recovery beat is produced.
- Latency:
  - Request in IDLE at cycle t: grant registered at edge t+1, first beat can transfer in cycle t+1.
  - Back-to-back packets from different masters: 0 idle cycles.
- Combinational paths: i_m_tready→o_s_tready and granted-master inputs→o_m_*. No combinational path from tvalid to tready.
- AXI rules held: o_m_tvalid never depends on i_m_tready. Once asserted, the payload is stable until the handshake, provided upstream obeys AXI.
- Simultaneous tlast handshake and new requests: the decision uses the masked pick in the same cycle.
- pkt_cnt wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package axis_ic_pkg:
  - state enum {IDLE, XFER}
  - default DATA_W/DEST_W constants
  - helper function onehot→index
- Sub-module axis_rr_pick: combinational round-robin picker. Inputs: req[N-1:0], last index, mask. Outputs: one-hot grant, index, any_req.
- Top level: state register, grant/last_grant registers, muxes, counter.

## Test plan
- Reset release, masters 0 and 2 both valid with 3-beat packets → master 0 granted first (o_grant=0001). All 3 beats forwarded, then master 2 with no bubble. o_pkt_cnt=2.
- All 4 masters continuously valid with 1-beat packets → grant order 0,1,2,3,0,… Each tlast beat is accepted in consecutive cycles.
- Downstream i_m_tready toggling 1,0,1 during a packet from master 1 → o_s_tready[1] tracks tready exactly. No beat is duplicated or lost, and the payload is held while stalled.
- Master 3 mid-packet drops tvalid for 2 cycles while master 0 is valid → the grant stays on master 3 until its tlast handshake. Master 0 is then served.
- Assert i_srst_n=0 mid-packet → o_m_tvalid, o_s_tready, o_grant and o_busy drop to 0 asynchronously. After release, master 0 has priority again.
- CNT_W=4 with 17 packets → o_pkt_cnt reads 1.
